// File: rtl/i2c_dec_pkg.sv
// State encoding and default parameter values shared by the I2C frame decoder
// and its synchronizer sub-module.
`timescale 1ns/1ps
package i2c_dec_pkg;
    localparam int DEF_DATA_W         = 8;
    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_TIMEOUT_CYCLES = 65535;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        ACK  = 2'd2
    } dec_state_t;
endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer for one raw bus line, with rise/fall strobes
// derived from the synchronized value and its one-cycle-delayed copy.
`timescale 1ns/1ps
module i2c_sync_edge
    import i2c_dec_pkg::*;
#(
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    // Chain and history reset to 1 so an idle bus produces no edge after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  = r_sync[STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[STAGES-1] & r_prev;
endmodule

// File: rtl/i2c_frame_decoder.sv
// Passive I2C bus decoder: recovers START/STOP, data words and ACK bits from
// raw SCL/SDA and hands words to a consumer through a valid/ready register.
`timescale 1ns/1ps
module i2c_frame_decoder
    import i2c_dec_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              comms_clk,
    input  logic              data_in,
    input  logic              clear_err,
    input  logic              byte_ready,
    output logic              byte_valid,
    output logic [DATA_W-1:0] byte_data,
    output logic              byte_ack,
    output logic              byte_first,
    output logic              start_pulse,
    output logic              stop_pulse,
    output logic              wait_led,
    output logic              frame_err,
    output logic              overflow,
    output logic              timeout_err
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    logic w_sclLevel, w_sclRise, w_sclFall;
    logic w_sdaLevel, w_sdaRise, w_sdaFall;
    logic w_sclHeld, w_start, w_stop;

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sclSync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_async(comms_clk),
        .o_level(w_sclLevel),
        .o_rise (w_sclRise),
        .o_fall (w_sclFall)
    );

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sdaSync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_async(data_in),
        .o_level(w_sdaLevel),
        .o_rise (w_sdaRise),
        .o_fall (w_sdaFall)
    );

    // SCL high now and not rising means it was also high on the previous sample.
    assign w_sclHeld = w_sclLevel & ~w_sclRise;
    assign w_start   = w_sdaFall & w_sclHeld;
    assign w_stop    = w_sdaRise & w_sclHeld;

    logic r_evStart, r_evStop, r_evRise, r_evFall, r_evSda;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_evStart <= 1'b0;
            r_evStop  <= 1'b0;
            r_evRise  <= 1'b0;
            r_evFall  <= 1'b0;
            r_evSda   <= 1'b1;
        end else begin
            r_evStart <= w_start;
            r_evStop  <= w_stop;
            r_evRise  <= w_sclRise;
            r_evFall  <= w_sclFall;
            r_evSda   <= w_sdaLevel;
        end
    end

    dec_state_t        r_state;
    logic [CNT_W-1:0]  r_bitCnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_first;
    logic              r_bitVal;
    logic              r_bitPend;
    logic [TO_W-1:0]   r_toCnt;
    logic              r_byteValid;
    logic [DATA_W-1:0] r_byteData;
    logic              r_byteAck;
    logic              r_byteFirst;
    logic              r_startPulse;
    logic              r_stopPulse;
    logic              r_frameErr;
    logic              r_overflow;
    logic              r_timeoutErr;

    // A data bit is sampled on SCL rise but only committed once SCL falls, so
    // the SCL rise that precedes a STOP or repeated START never counts as data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_bitCnt     <= '0;
            r_shift      <= '0;
            r_first      <= 1'b0;
            r_bitVal     <= 1'b0;
            r_bitPend    <= 1'b0;
            r_toCnt      <= '0;
            r_byteValid  <= 1'b0;
            r_byteData   <= '0;
            r_byteAck    <= 1'b0;
            r_byteFirst  <= 1'b0;
            r_startPulse <= 1'b0;
            r_stopPulse  <= 1'b0;
            r_frameErr   <= 1'b0;
            r_overflow   <= 1'b0;
            r_timeoutErr <= 1'b0;
        end else begin
            r_startPulse <= r_evStart;
            r_stopPulse  <= r_evStop;
            if (clear_err) begin
                r_frameErr   <= 1'b0;
                r_overflow   <= 1'b0;
                r_timeoutErr <= 1'b0;
            end
            if (r_byteValid && byte_ready) begin
                r_byteValid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    r_toCnt <= '0;
                    if (r_evStart) begin
                        r_state   <= DATA;
                        r_bitCnt  <= '0;
                        r_shift   <= '0;
                        r_bitPend <= 1'b0;
                        r_first   <= 1'b1;
                    end
                end
                default: begin
                    if (r_evStart || r_evStop) begin
                        if (r_state == ACK || r_bitCnt != '0) begin
                            r_frameErr <= 1'b1;
                        end
                        r_state   <= r_evStart ? DATA : IDLE;
                        r_bitCnt  <= '0;
                        r_shift   <= '0;
                        r_bitPend <= 1'b0;
                        r_toCnt   <= '0;
                        r_first   <= r_evStart;
                    end else if (!r_evRise && !r_evFall &&
                                 r_toCnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        r_state      <= IDLE;
                        r_timeoutErr <= 1'b1;
                        r_toCnt      <= '0;
                        r_bitCnt     <= '0;
                        r_bitPend    <= 1'b0;
                    end else begin
                        r_toCnt <= (r_evRise || r_evFall) ? '0 : r_toCnt + 1'b1;
                        if (r_state == DATA) begin
                            if (r_evRise) begin
                                r_bitVal  <= r_evSda;
                                r_bitPend <= 1'b1;
                            end else if (r_evFall && r_bitPend) begin
                                r_shift   <= {r_shift[DATA_W-2:0], r_bitVal};
                                r_bitPend <= 1'b0;
                                if (r_bitCnt == CNT_W'(DATA_W - 1)) begin
                                    r_state  <= ACK;
                                    r_bitCnt <= '0;
                                end else begin
                                    r_bitCnt <= r_bitCnt + 1'b1;
                                end
                            end
                        end else if (r_evRise) begin
                            r_state  <= DATA;
                            r_bitCnt <= '0;
                            r_first  <= 1'b0;
                            if (r_byteValid && !byte_ready) begin
                                r_overflow <= 1'b1;
                            end else begin
                                r_byteValid <= 1'b1;
                                r_byteData  <= r_shift;
                                r_byteAck   <= r_evSda;
                                r_byteFirst <= r_first;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign byte_valid  = r_byteValid;
    assign byte_data   = r_byteData;
    assign byte_ack    = r_byteAck;
    assign byte_first  = r_byteFirst;
    assign start_pulse = r_startPulse;
    assign stop_pulse  = r_stopPulse;
    assign wait_led    = (r_state == IDLE);
    assign frame_err   = r_frameErr;
    assign overflow    = r_overflow;
    assign timeout_err = r_timeoutErr;
endmodule

// File: tb/tb_i2c_frame_decoder.sv
// Self-checking bench for i2c_frame_decoder: an 8-bit instance with a short
// timeout and a 12-bit instance share one bit-banged bus; a scoreboard checks words.
`timescale 1ns/1ps
module tb_i2c_frame_decoder;
    localparam int CLK   = 10;
    localparam int DRV   = 2;
    localparam int QTR   = 4;
    localparam int HALF  = 8;
    localparam int SYNC8 = 2;
    localparam int LAT   = (SYNC8 + 2) * CLK + CLK / 2 - DRV;

    typedef struct {
        logic [15:0] data;
        logic        ack;
        logic        first;
    } exp_t;

    typedef struct {
        logic [7:0] word;
        logic       ackBit;
        logic [7:0] expData;
        logic       expAck;
        logic       expFirst;
    } vec_t;

    logic clk, rst_n, comms_clk, data_in, clear_err, byte_ready;
    logic v8, a8, f8, sp8, pp8, w8, fe8, ov8, te8;
    logic [7:0] d8;
    logic v12, a12, f12, sp12, pp12, w12, fe12, ov12, te12;
    logic [11:0] d12;

    int   checks, errors;
    int   activeW;
    int   startCnt8, stopCnt8, stopCnt12, xferCnt, validRise8;
    logic prevV8;
    time  lastRiseT, ackRiseT, validRiseT;
    exp_t sbQ[$];
    vec_t vecs[5];

    i2c_frame_decoder #(.DATA_W(8), .SYNC_STAGES(SYNC8), .TIMEOUT_CYCLES(100)) dut8 (
        .clk(clk), .rst_n(rst_n), .comms_clk(comms_clk), .data_in(data_in),
        .clear_err(clear_err), .byte_ready(byte_ready), .byte_valid(v8),
        .byte_data(d8), .byte_ack(a8), .byte_first(f8), .start_pulse(sp8),
        .stop_pulse(pp8), .wait_led(w8), .frame_err(fe8), .overflow(ov8),
        .timeout_err(te8)
    );

    i2c_frame_decoder #(.DATA_W(12), .SYNC_STAGES(3), .TIMEOUT_CYCLES(1000)) dut12 (
        .clk(clk), .rst_n(rst_n), .comms_clk(comms_clk), .data_in(data_in),
        .clear_err(clear_err), .byte_ready(byte_ready), .byte_valid(v12),
        .byte_data(d12), .byte_ack(a12), .byte_first(f12), .start_pulse(sp12),
        .stop_pulse(pp12), .wait_led(w12), .frame_err(fe12), .overflow(ov12),
        .timeout_err(te12)
    );

    initial begin
        clk = 1'b0;
        forever #(CLK / 2) clk = ~clk;
    end

    initial begin
        #(CLK * 50000);
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic pushExp(input logic [15:0] data, input logic ack, input logic first);
        exp_t e;
        e.data  = data;
        e.ack   = ack;
        e.first = first;
        sbQ.push_back(e);
    endtask

    task automatic scoreCompare(input logic [15:0] data, input logic ack, input logic first);
        exp_t e;
        xferCnt++;
        if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL xfer_unexpected actual=0x%0h expected=none", data);
        end else begin
            e = sbQ.pop_front();
            checkOutput("xfer_data", 32'(data), 32'(e.data));
            checkOutput("xfer_ack", 32'(ack), 32'(e.ack));
            checkOutput("xfer_first", 32'(first), 32'(e.first));
        end
    endtask

    // Monitor samples on the falling edge, half a cycle away from the DUT's active edge.
    always @(negedge clk) begin
        if (sp8) startCnt8++;
        if (pp8) stopCnt8++;
        if (pp12) stopCnt12++;
        if (v8 && !prevV8) begin
            validRise8++;
            validRiseT = $time;
        end
        prevV8 = v8;
        if (activeW == 8 && v8 && byte_ready) scoreCompare({8'h00, d8}, a8, f8);
        if (activeW == 12 && v12 && byte_ready) scoreCompare({4'h0, d12}, a12, f12);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #DRV;
        end
    endtask

    task automatic sendStart();
        if (!comms_clk) begin
            data_in = 1'b1;
            tick(QTR);
            comms_clk = 1'b1;
            tick(HALF);
        end
        data_in = 1'b0;
        tick(HALF);
        comms_clk = 1'b0;
        tick(QTR);
    endtask

    task automatic sendStop();
        data_in = 1'b0;
        tick(QTR);
        comms_clk = 1'b1;
        tick(HALF);
        data_in = 1'b1;
        tick(HALF);
    endtask

    task automatic sendBit(input logic b);
        data_in = b;
        tick(QTR);
        comms_clk = 1'b1;
        lastRiseT = $time;
        tick(HALF);
        comms_clk = 1'b0;
        tick(QTR);
    endtask

    task automatic sendWord(input logic [15:0] word, input int nbits, input logic ackBit);
        for (int i = nbits - 1; i >= 0; i--) sendBit(word[i]);
        sendBit(ackBit);
        ackRiseT = lastRiseT;
    endtask

    task automatic applyStimulus(input logic [15:0] word, input int nbits, input logic ackBit, input bit withStop);
        sendStart();
        sendWord(word, nbits, ackBit);
        if (withStop) sendStop();
    endtask

    task automatic pulseClear();
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
        tick(1);
    endtask

    initial begin
        int s0, p0, x0, r0, waited, total;
        checks = 0; errors = 0; activeW = 8;
        startCnt8 = 0; stopCnt8 = 0; stopCnt12 = 0; xferCnt = 0; validRise8 = 0;
        prevV8 = 1'b0; lastRiseT = 0; ackRiseT = 0; validRiseT = 0;
        rst_n = 1'b0; comms_clk = 1'b1; data_in = 1'b1;
        clear_err = 1'b0; byte_ready = 1'b1;

        vecs[0] = '{8'hA4, 1'b0, 8'hA4, 1'b0, 1'b1};
        vecs[1] = '{8'h00, 1'b1, 8'h00, 1'b1, 1'b1};
        vecs[2] = '{8'hFF, 1'b0, 8'hFF, 1'b0, 1'b1};
        vecs[3] = '{8'h5A, 1'b1, 8'h5A, 1'b1, 1'b1};
        vecs[4] = '{8'h81, 1'b0, 8'h81, 1'b0, 1'b1};

        tick(5);
        checkOutput("rst_valid", 32'(v8), 0);
        checkOutput("rst_data", 32'(d8), 0);
        checkOutput("rst_pulses", {30'd0, sp8, pp8}, 0);
        checkOutput("rst_flags", {29'd0, fe8, ov8, te8}, 0);
        checkOutput("rst_wait_led", 32'(w8), 1);
        rst_n = 1'b1;
        tick(5);

        $display("[TB] single-word frames");
        for (int i = 0; i < 5; i++) begin
            s0 = startCnt8; p0 = stopCnt8; x0 = xferCnt;
            pushExp({8'h00, vecs[i].expData}, vecs[i].expAck, vecs[i].expFirst);
            applyStimulus({8'h00, vecs[i].word}, 8, vecs[i].ackBit, 1'b1);
            tick(10);
            checkOutput("vec_drained", sbQ.size(), 0);
            checkOutput("vec_xfers", xferCnt - x0, 1);
            checkOutput("vec_start_pulses", startCnt8 - s0, 1);
            checkOutput("vec_stop_pulses", stopCnt8 - p0, 1);
            checkOutput("vec_valid_latency", 32'(validRiseT - ackRiseT), LAT);
            checkOutput("vec_wait_led", 32'(w8), 1);
            checkOutput("vec_frame_err", 32'(fe8), 0);
        end

        $display("[TB] repeated START");
        s0 = startCnt8; p0 = stopCnt8; x0 = xferCnt;
        pushExp(16'h0050, 1'b0, 1'b1);
        pushExp(16'h0051, 1'b0, 1'b1);
        sendStart();
        sendWord(16'h0050, 8, 1'b0);
        sendStart();
        sendWord(16'h0051, 8, 1'b0);
        sendStop();
        tick(10);
        checkOutput("rs_drained", sbQ.size(), 0);
        checkOutput("rs_xfers", xferCnt - x0, 2);
        checkOutput("rs_start_pulses", startCnt8 - s0, 2);
        checkOutput("rs_stop_pulses", stopCnt8 - p0, 1);
        checkOutput("rs_frame_err", 32'(fe8), 0);

        $display("[TB] STOP inside a word");
        r0 = validRise8;
        sendStart();
        sendBit(1'b1);
        sendBit(1'b0);
        sendBit(1'b1);
        sendStop();
        tick(10);
        checkOutput("short_frame_err", 32'(fe8), 1);
        checkOutput("short_wait_led", 32'(w8), 1);
        checkOutput("short_no_valid", validRise8 - r0, 0);
        pulseClear();
        checkOutput("short_err_cleared", 32'(fe8), 0);

        $display("[TB] overflow with consumer stalled");
        byte_ready = 1'b0;
        pushExp(16'h0011, 1'b0, 1'b1);
        sendStart();
        sendWord(16'h0011, 8, 1'b0);
        sendWord(16'h0022, 8, 1'b0);
        sendWord(16'h0033, 8, 1'b0);
        sendStop();
        tick(10);
        checkOutput("ovf_valid_held", 32'(v8), 1);
        checkOutput("ovf_data_held", 32'(d8), 32'h11);
        checkOutput("ovf_first_held", 32'(f8), 1);
        checkOutput("ovf_flag", 32'(ov8), 1);
        checkOutput("ovf_no_frame_err", 32'(fe8), 0);
        byte_ready = 1'b1;
        tick(1);
        byte_ready = 1'b0;
        tick(2);
        checkOutput("ovf_valid_dropped", 32'(v8), 0);
        checkOutput("ovf_drained", sbQ.size(), 0);
        pulseClear();
        checkOutput("ovf_cleared", 32'(ov8), 0);
        byte_ready = 1'b1;

        $display("[TB] SCL stalled mid-word");
        sendStart();
        sendBit(1'b1);
        sendBit(1'b1);
        sendBit(1'b0);
        tick(50);
        checkOutput("to_not_early", 32'(te8), 0);
        checkOutput("to_busy_before", 32'(w8), 0);
        waited = 50;
        while (!te8 && waited < 300) begin
            tick(1);
            waited++;
        end
        total = waited + QTR;
        checkOutput("to_seen", 32'(te8), 1);
        checkOutput("to_window", 32'(total >= 100 && total <= 100 + SYNC8 + 4), 1);
        checkOutput("to_wait_led", 32'(w8), 1);
        checkOutput("to_no_frame_err", 32'(fe8), 0);
        comms_clk = 1'b1;
        tick(QTR);
        data_in = 1'b1;
        tick(HALF);
        pulseClear();
        checkOutput("to_cleared", 32'(te8), 0);

        $display("[TB] reset mid-word on the 12-bit decoder");
        activeW = 12;
        sendStart();
        for (int i = 0; i < 5; i++) sendBit(i[0]);
        rst_n = 1'b0;
        data_in = 1'b1;
        tick(2);
        comms_clk = 1'b1;
        tick(4);
        checkOutput("r12_valid", 32'(v12), 0);
        checkOutput("r12_data", 32'(d12), 0);
        checkOutput("r12_ack_first", {30'd0, a12, f12}, 0);
        checkOutput("r12_pulses", {30'd0, sp12, pp12}, 0);
        checkOutput("r12_flags", {29'd0, fe12, ov12, te12}, 0);
        checkOutput("r12_wait_led", 32'(w12), 1);
        p0 = stopCnt12;
        rst_n = 1'b1;
        tick(10);
        checkOutput("r12_no_stop_pulse", stopCnt12 - p0, 0);
        checkOutput("r12_no_frame_err", 32'(fe12), 0);
        pushExp(16'h0A5C, 1'b1, 1'b1);
        applyStimulus(16'h0A5C, 12, 1'b1, 1'b1);
        tick(10);
        checkOutput("r12_drained", sbQ.size(), 0);
        checkOutput("r12_frame_err_after", 32'(fe12), 0);
        checkOutput("r12_wait_led_after", 32'(w12), 1);

        checkOutput("final_drained", sbQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2c_frame_decoder.md
I2C_FRAME_DECODER -- requirements
Module: i2c_frame_decoder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter DATA_W, default 8, SHALL set the bits per data word (range 4..16).
REQ-003 Parameter SYNC_STAGES, default 2, SHALL set the input synchronizer depth (range 2..4).
REQ-004 Parameter TIMEOUT_CYCLES, default 65535, SHALL set the clk cycles without a comms_clk edge before abort.
REQ-005 Ports SHALL be:
 clk  in  1  system clock
 rst_n  in  1  synchronous active-low reset
 comms_clk  in  1  raw SCL, asynchronous
 data_in  in  1  raw SDA, asynchronous
 clear_err  in  1  clears sticky error flags
 byte_ready  in  1  consumer accepts byte
 byte_valid  out  1  byte holding register full
 byte_data  out  DATA_W  received word, MSB first on bus
 byte_ack  out  1  sampled ACK bit (0 = ACK)
 byte_first  out  1  word is first after START/repeated START (address)
 start_pulse  out  1  one-cycle START/repeated-START strobe
 stop_pulse  out  1  one-cycle STOP strobe
 wait_led  out  1  high while bus idle
 frame_err  out  1  sticky: START/STOP inside a word
 overflow  out  1  sticky: word dropped, holding register full
 timeout_err  out  1  sticky: SCL stalled mid-frame

Function
REQ-006 comms_clk and data_in SHALL pass through SYNC_STAGES flops; all decoding SHALL use synchronized values s_scl, s_sda and their one-cycle-delayed copies.
REQ-007 START SHALL be detected when s_sda falls while s_scl is high in both the current and previous sample; STOP SHALL be detected when s_sda rises under the same condition.
REQ-008 A bit SHALL be sampled on an s_scl rising edge; an s_sda edge in the same cycle SHALL count as data, not START/STOP.
REQ-009 The FSM SHALL have states IDLE, DATA, and ACK.
REQ-010 IDLE: START SHALL move to DATA, clear the bit counter, and set the first-word flag; all other events SHALL be ignored.
REQ-011 DATA: each sampled bit SHALL shift into the LSB; after DATA_W bits the FSM SHALL move to ACK.
REQ-012 ACK: the sampled bit SHALL become byte_ack; the word SHALL be offered at the output; the FSM SHALL return to DATA with the counter cleared and the first-word flag cleared.
REQ-013 START in DATA or ACK SHALL be a repeated START: the FSM SHALL go to DATA, clear the counter, and set the first-word flag.
REQ-014 STOP in any non-IDLE state SHALL go to IDLE.
REQ-015 START or STOP in DATA with counter nonzero, or in ACK, SHALL set frame_err and discard the partial word.
REQ-016 start_pulse and stop_pulse SHALL assert for exactly one cycle, registered, on the cycle after detection.
REQ-017 byte_valid SHALL rise on the clk edge after the ACK-bit s_scl rise is detected, which is SYNC_STAGES+2 clk after the raw edge.
REQ-018 byte_data, byte_ack, and byte_first SHALL be stable while byte_valid is high.
REQ-019 A transfer SHALL occur when byte_valid and byte_ready are both high; byte_valid SHALL then drop next cycle unless a new word loads in that same cycle.
REQ-020 A word completing while byte_valid is high and byte_ready is low SHALL be dropped and SHALL set overflow; the held word SHALL be unchanged.
REQ-021 In DATA or ACK, a counter SHALL count cycles without an s_scl edge.
REQ-022 When that counter reaches TIMEOUT_CYCLES, the FSM SHALL go to IDLE and set timeout_err.
REQ-023 The timeout counter SHALL clear on any s_scl edge or on entry to IDLE.
REQ-024 clear_err SHALL clear all sticky flags next cycle; a simultaneous set SHALL take priority over clear.
REQ-025 wait_led SHALL be high exactly when the FSM is in IDLE.

Reset
REQ-026 On rst_n low at a clk edge: FSM to IDLE; counters, shift register, and synchronizers to idle-bus value 1 (synchronizers) or 0 (counters, shift register).
REQ-027 On reset, outputs SHALL be: byte_valid, byte_data, byte_ack, byte_first, pulses, and error flags = 0; wait_led = 1.
REQ-028 Reset mid-frame SHALL abandon the frame without asserting frame_err or stop_pulse.

Structure
REQ-029 Package i2c_dec_pkg SHALL hold the state encoding (IDLE=0, DATA=1, ACK=2) and default parameter constants.
REQ-030 Sub-module i2c_sync_edge SHALL implement one synchronizer with rise/fall detection and SHALL be instantiated twice.

Verification
REQ-031 START, then 0xA4 with ACK=0, then STOP, byte_ready=1 -> one transfer (byte_data=0xA4, byte_ack=0, byte_first=1), one start_pulse, one stop_pulse, wait_led high at end.
REQ-032 START, 0x50, repeated START, 0x51, STOP -> two transfers with byte_first=1 both, two start_pulses.
REQ-033 byte_ready=0, then three words 0x11, 0x22, 0x33 -> held byte_data=0x11, overflow=1; clear_err -> overflow=0.
REQ-034 STOP after 3 data bits -> frame_err=1, no byte_valid, FSM to IDLE.
REQ-035 TIMEOUT_CYCLES=100, SCL held low mid-word -> timeout_err=1 and wait_led=1 at cycle 100.
REQ-036 DATA_W=12 with rst_n low mid-word -> all outputs at reset values; the next frame decodes correctly.
